// File: rtl/jpeg_bit_packer.sv
// jpeg_bit_packer
//   Packs variable-length, right-aligned codes (Huffman code + amplitude bits)
//   into a byte stream, MSB first. After every 0xFF data byte a 0x00 stuff
//   byte is inserted. A flush request pads the last partial byte with 1 bits,
//   drains every residual byte and then pulses flush_done.
//
// Ports
//   clk         : sole clock, rising edge
//   reset       : asynchronous, active-low reset
//   enable      : code_in/len_in valid this cycle
//   code_in     : right-aligned code, sent MSB first
//   len_in      : number of valid bits in code_in (values above CODE_W clamp)
//   flush       : request to pad and emit all residual bits
//   ready       : enable/flush are accepted this cycle
//   byte_out    : packed output byte
//   data_valid  : byte_out holds a valid byte
//   out_ready   : downstream consumes byte_out when data_valid is high
//   flush_done  : one-cycle pulse once a flush has fully drained
//   dbg_state   : FSM state (0 = RUN, 1 = STUFF)
//   dbg_count   : number of bits held in the accumulator
//
// Handshakes
//   Input side : a code/flush transfers on a rising edge where
//                (enable|flush) & ready; ready depends only on registered
//                state (and reset), never on enable/flush.
//   Output side: a byte transfers on a rising edge where
//                data_valid & out_ready; while data_valid & !out_ready the
//                byte and data_valid stay frozen.
module jpeg_bit_packer #(
  parameter int CODE_W = 27,
  parameter int LEN_W  = 5,
  localparam int ACC_W = CODE_W + 8,
  localparam int CNT_W = $clog2(ACC_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [CODE_W-1:0] code_in,
  input  logic [LEN_W-1:0]  len_in,
  input  logic              flush,
  output logic              ready,
  output logic [7:0]        byte_out,
  output logic              data_valid,
  input  logic              out_ready,
  output logic              flush_done,
  output logic              dbg_state,
  output logic [CNT_W-1:0]  dbg_count
);

  typedef enum logic {
    RUN   = 1'b0,
    STUFF = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               flush_pend_q, flush_pend_d;
  logic [7:0]         byte_out_q, byte_out_d;
  logic               data_valid_q, data_valid_d;
  logic               flush_done_q, flush_done_d;

  logic               slot_free;
  logic               accept;
  logic [CNT_W-1:0]   len_ext;
  logic [ACC_W-1:0]   code_ext;
  logic [CNT_W-1:0]   shamt;
  logic [7:0]         top_byte;

  // ready is held low while reset is asserted even though the reset state
  // would otherwise allow input.
  assign ready = reset & (state_q == RUN) & (count_q < CNT_W'(8)) & ~flush_pend_q;

  assign slot_free = ~data_valid_q | out_ready;
  assign accept    = ready & (enable | flush);
  assign top_byte  = acc_q[ACC_W-1 -: 8];

  // Clamp length and isolate the valid low bits of the code.
  always_comb begin
    len_ext = CNT_W'(len_in);
    if (int'(len_in) > CODE_W) begin
      len_ext = CNT_W'(CODE_W);
    end
  end

  assign code_ext = ACC_W'(code_in) & ~({ACC_W{1'b1}} << len_ext);

  // New bits land directly below the existing MSB-aligned bits. Accept only
  // happens with count < 8, so the shift is always at least 1.
  assign shamt = CNT_W'(ACC_W) - count_q - len_ext;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    count_d      = count_q;
    flush_pend_d = flush_pend_q;
    byte_out_d   = byte_out_q;
    data_valid_d = data_valid_q;
    flush_done_d = 1'b0;

    // A consumed (or empty) slot goes invalid unless something reloads it.
    if (slot_free) begin
      data_valid_d = 1'b0;
    end

    case (state_q)
      STUFF: begin
        if (slot_free) begin
          byte_out_d   = 8'h00;
          data_valid_d = 1'b1;
          state_d      = RUN;
        end
      end

      default: begin
        if (accept) begin
          if (enable) begin
            acc_d   = acc_q | (code_ext << shamt);
            count_d = count_q + len_ext;
          end
          if (flush) begin
            // Nothing left to drain: finish the flush right away.
            if ((count_d == '0) && slot_free) begin
              flush_done_d = 1'b1;
            end else begin
              flush_pend_d = 1'b1;
            end
          end
        end else if ((count_q >= CNT_W'(8)) && slot_free) begin
          byte_out_d   = top_byte;
          data_valid_d = 1'b1;
          acc_d        = acc_q << 8;
          count_d      = count_q - CNT_W'(8);
          if (top_byte == 8'hFF) begin
            state_d = STUFF;
          end
        end else if (flush_pend_q && (count_q != '0) && slot_free) begin
          // Bits below count are always zero, so OR-ing in ones pads the
          // partial byte with 1 bits.
          byte_out_d   = top_byte | (8'hFF >> count_q);
          data_valid_d = 1'b1;
          acc_d        = '0;
          count_d      = '0;
          if ((top_byte | (8'hFF >> count_q)) == 8'hFF) begin
            state_d = STUFF;
          end
        end else if (flush_pend_q && (count_q == '0) && slot_free) begin
          flush_done_d = 1'b1;
          flush_pend_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RUN;
      acc_q        <= '0;
      count_q      <= '0;
      flush_pend_q <= 1'b0;
      byte_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      count_q      <= count_d;
      flush_pend_q <= flush_pend_d;
      byte_out_q   <= byte_out_d;
      data_valid_q <= data_valid_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign byte_out   = byte_out_q;
  assign data_valid = data_valid_q;
  assign flush_done = flush_done_q;
  assign dbg_state  = state_q;
  assign dbg_count  = count_q;

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// tb_jpeg_bit_packer
//   Self-checking bench for jpeg_bit_packer. A bit-queue reference model
//   turns accepted codes into the expected byte stream (0x00 after 0xFF,
//   1-padding on flush); a negedge monitor compares every transferred byte.
module tb_jpeg_bit_packer;
  localparam int CODE_W = 27;
  localparam int LEN_W  = 5;
  localparam int CNT_W  = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b0;
  logic [CODE_W-1:0] code_in = '0;
  logic [LEN_W-1:0]  len_in = '0;
  logic              flush = 1'b0;
  logic              out_ready = 1'b1;
  logic              ready;
  logic [7:0]        byte_out;
  logic              data_valid;
  logic              flush_done;
  logic              dbg_state;
  logic [CNT_W-1:0]  dbg_count;

  jpeg_bit_packer #(.CODE_W(CODE_W), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .code_in    (code_in),
    .len_in     (len_in),
    .flush      (flush),
    .ready      (ready),
    .byte_out   (byte_out),
    .data_valid (data_valid),
    .out_ready  (out_ready),
    .flush_done (flush_done),
    .dbg_state  (dbg_state),
    .dbg_count  (dbg_count)
  );

  // clock
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit         bit_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         fd_exp = 0;
  int         fd_seen = 0;
  bit         rand_on = 1'b0;

  // monitor state
  bit         hold_prev = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  bit         fd_prev = 1'b0;

  task automatic model_pack();
    logic [7:0] b;
    while (bit_q.size() >= 8) begin
      b = 8'h00;
      for (int i = 0; i < 8; i++) b = {b[6:0], bit_q.pop_front()};
      exp_q.push_back(b);
      if (b == 8'hFF) exp_q.push_back(8'h00);
    end
  endtask

  task automatic model_accept(input logic [CODE_W-1:0] code, input int len,
                              input bit en, input bit fl);
    int l;
    if (en) begin
      l = (len > CODE_W) ? CODE_W : len;
      for (int i = l - 1; i >= 0; i--) bit_q.push_back(code[i]);
      model_pack();
    end
    if (fl) begin
      while ((bit_q.size() % 8) != 0) bit_q.push_back(1'b1);
      model_pack();
      fd_exp++;
    end
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    logic [7:0] e;
    if (!reset) begin
      hold_prev = 1'b0;
      fd_prev   = 1'b0;
    end else begin
      if (hold_prev) begin
        checks++;
        if (data_valid !== 1'b1 || byte_out !== prev_byte) begin
          errors++;
          $display("FAIL hold: byte_out=%h data_valid=%b, required byte_out=%h data_valid=1",
                   byte_out, data_valid, prev_byte);
        end
      end
      if (data_valid === 1'b1 && out_ready) begin
        obs_q.push_back(byte_out);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream: got byte %h, required no byte", byte_out);
        end else begin
          e = exp_q.pop_front();
          if (byte_out !== e) begin
            errors++;
            $display("FAIL stream: got byte %h, required %h", byte_out, e);
          end
        end
      end
      if (flush_done === 1'b1) begin
        fd_seen++;
        checks++;
        if (fd_prev || data_valid !== 1'b0 || exp_q.size() != 0) begin
          errors++;
          $display("FAIL flush_done: prev=%b data_valid=%b pending=%0d, required 0/0/0",
                   fd_prev, data_valid, exp_q.size());
        end
      end
      hold_prev = (data_valid === 1'b1) && !out_ready;
      prev_byte = byte_out;
      fd_prev   = (flush_done === 1'b1);
    end
  end

  // driver: hold the request until ready, transfer on the next edge
  task automatic send(input logic [CODE_W-1:0] code, input int len,
                      input bit en, input bit fl);
    int w = 0;
    enable  = en;
    code_in = code;
    len_in  = LEN_W'(len);
    flush   = fl;
    while (!ready && w < 300) begin
      @(posedge clk);
      #1;
      w++;
    end
    checks++;
    if (!ready) begin
      errors++;
      $display("FAIL send_timeout: ready=%b after %0d cycles, required 1", ready, w);
      enable = 1'b0;
      flush  = 1'b0;
    end else begin
      @(posedge clk);
      model_accept(code, len, en, fl);
      #1;
      enable = 1'b0;
      flush  = 1'b0;
    end
  endtask

  task automatic drain();
    int w = 0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    while ((exp_q.size() != 0 || data_valid === 1'b1 || fd_seen != fd_exp) && w < 500) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (exp_q.size() != 0 || fd_seen != fd_exp) begin
      errors++;
      $display("FAIL drain: pending=%0d flush_done seen=%0d, required pending=0 seen=%0d",
               exp_q.size(), fd_seen, fd_exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks += 4;
    if (byte_out !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h, required 00", byte_out); end
    if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", data_valid); end
    if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b, required 0", flush_done); end
    if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, required 0", ready); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b, required 1", ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_pack();
    obs_q.delete();
    send(CODE_W'(4'hA), 4, 1'b1, 1'b0);
    send(CODE_W'(4'h3), 4, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (data_valid !== 1'b0) begin errors++; $display("FAIL pack_latency0: data_valid=%b, required 0", data_valid); end
    @(negedge clk);
    checks++;
    if (data_valid !== 1'b1 || byte_out !== 8'hA3) begin
      errors++;
      $display("FAIL pack_latency1: data_valid=%b byte=%h, required 1 A3", data_valid, byte_out);
    end
    drain();
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== 8'hA3) begin
      errors++;
      $display("FAIL pack_stream: count=%0d first=%h, required 1 A3", obs_q.size(), obs_q[0]);
    end
  endtask

  task automatic test_stuff();
    obs_q.delete();
    send(CODE_W'(8'hFF), 8, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL stuff_ready_full: got %b, required 0", ready); end
    @(negedge clk);
    checks++;
    if (data_valid !== 1'b1 || byte_out !== 8'hFF || ready !== 1'b0) begin
      errors++;
      $display("FAIL stuff_ff: dv=%b byte=%h ready=%b, required 1 FF 0", data_valid, byte_out, ready);
    end
    @(negedge clk);
    checks++;
    if (data_valid !== 1'b1 || byte_out !== 8'h00) begin
      errors++;
      $display("FAIL stuff_00: dv=%b byte=%h, required 1 00", data_valid, byte_out);
    end
    drain();
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== 8'hFF || obs_q[1] !== 8'h00) begin
      errors++;
      $display("FAIL stuff_stream: count=%0d, required 2 bytes FF 00", obs_q.size());
    end
  endtask

  task automatic test_flush();
    int fd0;
    obs_q.delete();
    fd0 = fd_seen;
    send(CODE_W'(3'b101), 3, 1'b1, 1'b0);
    send('0, 0, 1'b0, 1'b1);
    drain();
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== 8'hBF || fd_seen != fd0 + 1) begin
      errors++;
      $display("FAIL flush_pad: count=%0d first=%h pulses=%0d, required 1 BF 1",
               obs_q.size(), obs_q[0], fd_seen - fd0);
    end
  endtask

  task automatic test_backpressure();
    obs_q.delete();
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(CODE_W'(16'h12F0), 16, 1'b1, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (data_valid !== 1'b1 || byte_out !== 8'h12) begin
        errors++;
        $display("FAIL bp_hold%0d: dv=%b byte=%h, required 1 12", i, data_valid, byte_out);
      end
    end
    drain();
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== 8'h12 || obs_q[1] !== 8'hF0) begin
      errors++;
      $display("FAIL bp_stream: count=%0d, required 2 bytes 12 F0", obs_q.size());
    end
  endtask

  task automatic test_flush_empty();
    send('0, 0, 1'b0, 1'b1);
    checks++;
    if (flush_done !== 1'b1 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_empty: flush_done=%b dv=%b, required 1 0", flush_done, data_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (flush_done !== 1'b0) begin errors++; $display("FAIL flush_empty_pulse: got %b, required 0", flush_done); end
  endtask

  task automatic test_len_edges();
    send(CODE_W'($urandom()), 0, 1'b1, 1'b0);
    send(CODE_W'(27'h5555_55A), 3, 1'b1, 1'b0);
    send(CODE_W'($urandom()), 31, 1'b1, 1'b0);
    send(CODE_W'($urandom()), 27, 1'b1, 1'b0);
    send(CODE_W'($urandom()), 5, 1'b1, 1'b1);
    drain();
  endtask

  task automatic test_reset_mid();
    obs_q.delete();
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(CODE_W'(13'h1FF6), 13, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (dbg_state !== 1'b1 || dbg_count !== CNT_W'(5) || byte_out !== 8'hFF) begin
      errors++;
      $display("FAIL rmid_setup: state=%b count=%0d byte=%h, required 1 5 FF", dbg_state, dbg_count, byte_out);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (byte_out !== 8'h00 || data_valid !== 1'b0 || ready !== 1'b0 || flush_done !== 1'b0) begin
      errors++;
      $display("FAIL rmid_clear: byte=%h dv=%b ready=%b fd=%b, required 00 0 0 0",
               byte_out, data_valid, ready, flush_done);
    end
    bit_q.delete();
    exp_q.delete();
    @(negedge clk);
    #2 reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (data_valid !== 1'b0) begin errors++; $display("FAIL rmid_quiet%0d: dv=%b byte=%h, required dv 0", i, data_valid, byte_out); end
    end
    @(posedge clk);
    #1;
    test_flush_empty();
  endtask

  task automatic test_random();
    logic [CODE_W-1:0] code;
    int  len;
    bit  fl;
    bit  en;
    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 150; i++) begin
      code = CODE_W'($urandom());
      if ($urandom_range(0, 3) == 0) code = '1;
      len = $urandom_range(0, 31);
      fl  = ($urandom_range(0, 9) == 0);
      en  = ($urandom_range(0, 7) != 0);
      send(code, len, en, fl);
    end
    send('0, 0, 1'b0, 1'b1);
    rand_on = 1'b0;
    repeat (2) @(posedge clk);
    #2 out_ready = 1'b1;
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_pack();
    test_stuff();
    test_flush();
    test_backpressure();
    test_flush_empty();
    test_len_edges();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jpeg_bit_packer.md
JPEG_BIT_PACKER -- requirements
Module: jpeg_bit_packer

Interface
REQ-001 SHALL have parameter CODE_W, default 27, max bits per input code (16 Huffman + 11 amplitude).
REQ-002 SHALL have parameter LEN_W, default 5, width of the length field.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-low; one clock domain.
REQ-005 SHALL have port enable  input  1  code_in/len_in valid this cycle.
REQ-006 SHALL have port code_in  input  CODE_W  right-aligned code, transmitted MSB first.
REQ-007 SHALL have port len_in  input  LEN_W  number of valid bits in code_in (0..CODE_W).
REQ-008 SHALL have port flush  input  1  request to pad and emit all residual bits.
REQ-009 SHALL have port ready  output  1  enable/flush are accepted this cycle.
REQ-010 SHALL have port byte_out  output  8  packed output byte.
REQ-011 SHALL have port data_valid  output  1  byte_out holds a valid byte.
REQ-012 SHALL have port out_ready  input  1  downstream consumes byte_out when data_valid is high.
REQ-013 SHALL have port flush_done  output  1  one-cycle pulse: flush fully drained.

Function
REQ-014 SHALL hold a bit accumulator of at least CODE_W+8 bits and a bit count, MSB-aligned.
REQ-015 SHALL drive ready = (state==RUN) & (count<8) & !flush_pend.
REQ-016 SHALL, on enable&ready, append the low len_in bits of code_in after existing bits; count += len_in; bits above len_in ignored.
REQ-017 SHALL treat len_in=0 as accepted with no change; len_in>CODE_W SHALL be clamped to CODE_W.
REQ-018 SHALL define output slot free = !data_valid | out_ready.
REQ-019 SHALL, in RUN with count>=8 and slot free, load top 8 bits to byte_out, set data_valid, count -= 8, shift accumulator.
REQ-020 SHALL, when slot free and no new byte loads, clear data_valid; byte_out keeps its value.
REQ-021 SHALL keep byte_out and data_valid stable while data_valid & !out_ready.
REQ-022 SHALL enter STUFF after loading 0xFF; in STUFF with slot free, load 0x00, set data_valid, return to RUN.
REQ-023 SHALL have states RUN and STUFF only; reset state RUN.
REQ-024 SHALL give latency: code accepted at edge N producing count>=8 yields data_valid after edge N+1 if slot free.
REQ-025 SHALL, on flush&ready, set flush_pend; if enable is also high, append the code first.
REQ-026 SHALL, with flush_pend, RUN, 0<count<8, slot free: pad with 1 bits to count=8, then emit per REQ-019 (stuffing applies).
REQ-027 SHALL, with flush_pend, RUN, count==0, slot free: pulse flush_done for one cycle, clear flush_pend, clear data_valid.
REQ-028 SHALL pulse flush_done immediately per REQ-027 if flush arrives with count==0 and no byte pending.
REQ-029 SHALL never drop or reorder bits; the output byte stream equals concatenated codes with 0x00 after every 0xFF.

Reset
REQ-030 SHALL, on reset low, asynchronously clear: byte_out=0x00, data_valid=0, flush_done=0, count=0, accumulator=0, flush_pend=0, state=RUN.
REQ-031 SHALL, while reset low, drive ready=0; ready=1 on the first cycle after release.
REQ-032 SHALL discard partial bits and pending stuff bytes on reset mid-operation.

Verification
REQ-033 SHALL cover: reset low -> byte_out=0x00, data_valid=0, flush_done=0; release -> ready=1.
REQ-034 SHALL cover: code 4'b1010 len 4, then 4'b0011 len 4, out_ready=1 -> single byte 0xA3.
REQ-035 SHALL cover: code 8'hFF len 8 -> bytes 0xFF then 0x00 on consecutive cycles; ready=0 during STUFF.
REQ-036 SHALL cover: code 3'b101 len 3 then flush -> byte 0xBF, then one-cycle flush_done.
REQ-037 SHALL cover: code 16'h12F0 len 16, out_ready=0 for 5 cycles -> byte_out holds 0x12; release -> 0x12, 0xF0 accepted in order.
REQ-038 SHALL cover: reset asserted with count=5 and STUFF pending -> outputs cleared at once; no 0x00 emitted after release.
